dealer_turn_fsm: RTL and testbench

Sequential dealer-turn controller and parametrised successor to the combinational dealer decision logic. Runs the whole dealer turn: pacing delay, hit/stand decision against a configurable threshold, hit request/acknowledge handshake with the card-dealing logic, card-count cap, bust detection and end-of-turn signalling. Sits between the game-control FSM (start/abort) and the deck/hand logic (card delivery).

---
 rtl/dealer_turn_fsm_pkg.sv | 23 ++
 rtl/dealer_decide.sv | 35 +++
 rtl/dealer_turn_fsm.sv | 115 +++++++++++
 tb/tb_dealer_turn_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dealer_turn_fsm_pkg.sv
// Shared types and constants for the dealer-turn controller.
package dealer_turn_fsm_pkg;

  localparam int BLACKJACK_LIMIT = 21;
  localparam int HAND_W_DEFAULT  = 5;

  typedef enum logic [1:0] {
    COMMAND_NONE  = 2'b00,
    COMMAND_HIT   = 2'b01,
    COMMAND_STAND = 2'b10
  } gameCommand;

  typedef logic [HAND_W_DEFAULT-1:0] handT;

  typedef enum logic [2:0] {
    IDLE,
    THINK,
    DECIDE,
    WAIT_CARD,
    DONE
  } dealerState;

endpackage

// File: rtl/dealer_decide.sv
// Combinational hit/stand/bust evaluator for the dealer turn.
// Build option HIT_SOFT_17_EN: dealer also hits a soft hand equal to the
// stand threshold; otherwise hand_soft has no effect.
module dealer_decide
  import dealer_turn_fsm_pkg::*;
#(
  parameter int HAND_W          = 5,
  parameter int CC_W            = 3,
  parameter int STAND_THRESHOLD = 17,
  parameter int MAX_CARDS       = 5
) (
  input  logic [HAND_W-1:0] handValue,
  input  logic              handSoft,
  input  logic [CC_W-1:0]   cardCount,
  output logic              bust,
  output logic              hit
);

  logic wantHit;

`ifdef HIT_SOFT_17_EN
  assign wantHit = (handValue < HAND_W'(STAND_THRESHOLD)) ||
                   ((handValue == HAND_W'(STAND_THRESHOLD)) && handSoft);
`else
  // Soft flag only matters when dealer hits soft 17.
  logic unusedSoft;
  assign unusedSoft = handSoft;
  assign wantHit    = handValue < HAND_W'(STAND_THRESHOLD);
`endif

  assign bust = handValue > HAND_W'(BLACKJACK_LIMIT);
  // Card cap turns a wanted hit into a forced stand.
  assign hit  = wantHit && (cardCount < CC_W'(MAX_CARDS));

endmodule

// File: rtl/dealer_turn_fsm.sv
// Dealer-turn controller: pacing delay, hit/stand decision, hit handshake
// with the dealing logic, card cap, bust tracking and end-of-turn pulse.
// Build option HIT_SOFT_17_EN selects the hit-soft-17 rule (see dealer_decide).
module dealer_turn_fsm
  import dealer_turn_fsm_pkg::*;
#(
  parameter int HAND_W          = 5,
  parameter int STAND_THRESHOLD = 17,
  parameter int MAX_CARDS       = 5,
  parameter int DECISION_DELAY  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             turn_start,
  input  logic                             turn_abort,
  input  logic [HAND_W-1:0]                hand_value,
  input  logic                             hand_soft,
  input  logic                             card_dealt,
  output gameCommand                       command,
  output logic                             cmd_valid,
  output logic                             turn_done,
  output logic                             busted,
  output logic [$clog2(MAX_CARDS+1)-1:0]   card_count
);

  localparam int CC_W  = $clog2(MAX_CARDS + 1);
  localparam int CNT_W = (DECISION_DELAY > 0) ? $clog2(DECISION_DELAY + 1) : 1;

  dealerState       state;
  logic [CNT_W-1:0] delayCnt;
  logic             bust;
  logic             hit;

  dealer_decide #(
    .HAND_W(HAND_W), .CC_W(CC_W),
    .STAND_THRESHOLD(STAND_THRESHOLD), .MAX_CARDS(MAX_CARDS)
  ) uDecide (
    .handValue(hand_value),
    .handSoft (hand_soft),
    .cardCount(card_count),
    .bust     (bust),
    .hit      (hit)
  );

  // Turn sequencing; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      command    <= COMMAND_NONE;
      cmd_valid  <= 1'b0;
      turn_done  <= 1'b0;
      busted     <= 1'b0;
      card_count <= '0;
      delayCnt   <= '0;
    end else if (turn_abort) begin
      // Abort beats everything, including a same-cycle card_dealt.
      state     <= IDLE;
      command   <= COMMAND_NONE;
      cmd_valid <= 1'b0;
      turn_done <= 1'b0;
    end else begin
      turn_done <= 1'b0;
      unique case (state)
        IDLE: begin
          command   <= COMMAND_NONE;
          cmd_valid <= 1'b0;
          if (turn_start) begin
            card_count <= '0;
            busted     <= 1'b0;
            delayCnt   <= CNT_W'(DECISION_DELAY);
            state      <= THINK;
          end
        end
        THINK: begin
          if (delayCnt == '0) state <= DECIDE;
          else                delayCnt <= delayCnt - 1'b1;
        end
        DECIDE: begin
          if (bust) begin
            busted    <= 1'b1;
            command   <= COMMAND_NONE;
            cmd_valid <= 1'b0;
            turn_done <= 1'b1;
            state     <= DONE;
          end else if (hit) begin
            command   <= COMMAND_HIT;
            cmd_valid <= 1'b1;
            state     <= WAIT_CARD;
          end else begin
            command   <= COMMAND_STAND;
            cmd_valid <= 1'b1;
            turn_done <= 1'b1;
            state     <= DONE;
          end
        end
        WAIT_CARD: begin
          if (card_dealt) begin
            card_count <= card_count + 1'b1;
            command    <= COMMAND_NONE;
            cmd_valid  <= 1'b0;
            delayCnt   <= CNT_W'(DECISION_DELAY);
            state      <= THINK;
          end
        end
        DONE: begin
          command   <= COMMAND_NONE;
          cmd_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dealer_turn_fsm.sv
// Directed bench: u0 uses default parameters, u1 uses MAX_CARDS=2 and
// DECISION_DELAY=0. Both share stimulus; each test checks one instance.
module tb_dealer_turn_fsm;
  import dealer_turn_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst_n, turn_start, turn_abort, hand_soft, card_dealt;
  logic [4:0] hand_value;
  gameCommand cmd0, cmd1;
  logic cv0, cv1, done0, done1, bust0, bust1;
  logic [2:0] cc0;
  logic [1:0] cc1;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dealer_turn_fsm u0 (
    .clk(clk), .rst_n(rst_n), .turn_start(turn_start), .turn_abort(turn_abort),
    .hand_value(hand_value), .hand_soft(hand_soft), .card_dealt(card_dealt),
    .command(cmd0), .cmd_valid(cv0), .turn_done(done0), .busted(bust0),
    .card_count(cc0)
  );

  dealer_turn_fsm #(.MAX_CARDS(2), .DECISION_DELAY(0)) u1 (
    .clk(clk), .rst_n(rst_n), .turn_start(turn_start), .turn_abort(turn_abort),
    .hand_value(hand_value), .hand_soft(hand_soft), .card_dealt(card_dealt),
    .command(cmd1), .cmd_valid(cv1), .turn_done(done1), .busted(bust1),
    .card_count(cc1)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic startTurn();
    turn_start = 1'b1; step(); turn_start = 1'b0;
  endtask

  task automatic abortTurn();
    turn_abort = 1'b1; step(); turn_abort = 1'b0;
  endtask

  task automatic dealCard();
    card_dealt = 1'b1; step(); card_dealt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; turn_start = 0; turn_abort = 0; hand_soft = 0; card_dealt = 0;
    hand_value = 5'd0;
    #12;
    vecs++; if (cmd0 !== COMMAND_NONE) begin errs++; $display("FAIL reset_cmd: got %0d exp 0", cmd0); end
    vecs++; if ({cv0, done0, bust0} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b exp 000", {cv0, done0, bust0}); end
    vecs++; if (cc0 !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d exp 0", cc0); end
    vecs++; if ({cv1, done1, bust1, cc1} !== 5'b0) begin errs++; $display("FAIL reset_u1: got %b exp 00000", {cv1, done1, bust1, cc1}); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_hit_then_stand();
    hand_value = 5'd12; hand_soft = 0;
    startTurn();
    repeat (3) step();
    vecs++; if (cv0 !== 1'b0) begin errs++; $display("FAIL think_quiet: got %b exp 0", cv0); end
    step();
    vecs++; if (cmd0 !== COMMAND_HIT || cv0 !== 1'b1) begin errs++; $display("FAIL first_hit: got cmd %0d v %b exp cmd 1 v 1", cmd0, cv0); end
    step(); step();
    vecs++; if (cmd0 !== COMMAND_HIT || cv0 !== 1'b1) begin errs++; $display("FAIL hit_hold: got cmd %0d v %b exp cmd 1 v 1", cmd0, cv0); end
    hand_value = 5'd19;
    dealCard();
    vecs++; if (cc0 !== 3'd1 || cv0 !== 1'b0 || cmd0 !== COMMAND_NONE) begin errs++; $display("FAIL card_ack: got cc %0d v %b cmd %0d exp cc 1 v 0 cmd 0", cc0, cv0, cmd0); end
    repeat (4) step();
    vecs++; if (cmd0 !== COMMAND_STAND || cv0 !== 1'b1 || done0 !== 1'b1) begin errs++; $display("FAIL stand: got cmd %0d v %b done %b exp cmd 2 v 1 done 1", cmd0, cv0, done0); end
    step();
    vecs++; if (done0 !== 1'b0 || cmd0 !== COMMAND_NONE || cv0 !== 1'b0 || bust0 !== 1'b0) begin errs++; $display("FAIL after_stand: got done %b cmd %0d v %b bust %b exp 0 0 0 0", done0, cmd0, cv0, bust0); end
  endtask

  task automatic test_bust();
    hand_value = 5'd16;
    startTurn();
    repeat (4) step();
    vecs++; if (cmd0 !== COMMAND_HIT) begin errs++; $display("FAIL bust_hit: got %0d exp 1", cmd0); end
    hand_value = 5'd24;
    dealCard();
    repeat (4) step();
    vecs++; if (cmd0 !== COMMAND_NONE || cv0 !== 1'b0 || done0 !== 1'b1 || bust0 !== 1'b1) begin errs++; $display("FAIL bust_done: got cmd %0d v %b done %b bust %b exp 0 0 1 1", cmd0, cv0, done0, bust0); end
    step();
    vecs++; if (bust0 !== 1'b1 || done0 !== 1'b0) begin errs++; $display("FAIL bust_sticky: got bust %b done %b exp 1 0", bust0, done0); end
    startTurn();
    vecs++; if (bust0 !== 1'b0 || cc0 !== 3'd0) begin errs++; $display("FAIL bust_clear: got bust %b cc %0d exp 0 0", bust0, cc0); end
    abortTurn();
  endtask

  task automatic test_soft17();
    gameCommand exp;
`ifdef HIT_SOFT_17_EN
    exp = COMMAND_HIT;
`else
    exp = COMMAND_STAND;
`endif
    hand_value = 5'd17; hand_soft = 1'b1;
    startTurn();
    repeat (4) step();
    vecs++; if (cmd0 !== exp || cv0 !== 1'b1) begin errs++; $display("FAIL soft17: got cmd %0d v %b exp cmd %0d v 1", cmd0, cv0, exp); end
    abortTurn();
    hand_soft = 1'b0;
    startTurn();
    repeat (4) step();
    vecs++; if (cmd0 !== COMMAND_STAND || done0 !== 1'b1) begin errs++; $display("FAIL hard17: got cmd %0d done %b exp cmd 2 done 1", cmd0, done0); end
    abortTurn();
  endtask

  task automatic test_max_cards();
    hand_value = 5'd10;
    startTurn();
    for (int i = 0; i < 5; i++) begin
      repeat (4) step();
      vecs++; if (cmd0 !== COMMAND_HIT || cc0 !== 3'(i)) begin errs++; $display("FAIL cap5_hit%0d: got cmd %0d cc %0d exp cmd 1 cc %0d", i, cmd0, cc0, i); end
      dealCard();
    end
    repeat (4) step();
    vecs++; if (cmd0 !== COMMAND_STAND || cc0 !== 3'd5 || done0 !== 1'b1) begin errs++; $display("FAIL cap5_stand: got cmd %0d cc %0d done %b exp 2 5 1", cmd0, cc0, done0); end
    abortTurn();
  endtask

  task automatic test_small_cap_zero_delay();
    hand_value = 5'd10;
    startTurn();
    step();
    vecs++; if (cv1 !== 1'b0) begin errs++; $display("FAIL d0_think: got %b exp 0", cv1); end
    step();
    vecs++; if (cmd1 !== COMMAND_HIT || cv1 !== 1'b1) begin errs++; $display("FAIL d0_hit: got cmd %0d v %b exp 1 1", cmd1, cv1); end
    dealCard();
    step(); step();
    vecs++; if (cmd1 !== COMMAND_HIT || cc1 !== 2'd1) begin errs++; $display("FAIL cap2_hit2: got cmd %0d cc %0d exp 1 1", cmd1, cc1); end
    dealCard();
    step(); step();
    vecs++; if (cmd1 !== COMMAND_STAND || cc1 !== 2'd2 || done1 !== 1'b1) begin errs++; $display("FAIL cap2_stand: got cmd %0d cc %0d done %b exp 2 2 1", cmd1, cc1, done1); end
    abortTurn();
  endtask

  task automatic test_abort_and_ignore();
    hand_value = 5'd12;
    startTurn();
    repeat (4) step();
    dealCard();
    repeat (4) step();
    turn_start = 1'b1; step(); turn_start = 1'b0;
    vecs++; if (cmd0 !== COMMAND_HIT || cc0 !== 3'd1) begin errs++; $display("FAIL busy_start: got cmd %0d cc %0d exp 1 1", cmd0, cc0); end
    card_dealt = 1'b1; turn_abort = 1'b1; step(); card_dealt = 1'b0; turn_abort = 1'b0;
    vecs++; if (cmd0 !== COMMAND_NONE || cv0 !== 1'b0 || done0 !== 1'b0 || cc0 !== 3'd1) begin errs++; $display("FAIL abort_deal: got cmd %0d v %b done %b cc %0d exp 0 0 0 1", cmd0, cv0, done0, cc0); end
    step();
    vecs++; if (done0 !== 1'b0 || cv0 !== 1'b0) begin errs++; $display("FAIL abort_quiet: got done %b v %b exp 0 0", done0, cv0); end
    dealCard();
    vecs++; if (cc0 !== 3'd1) begin errs++; $display("FAIL idle_deal: got %0d exp 1", cc0); end
    turn_start = 1'b1; turn_abort = 1'b1; step(); turn_start = 1'b0; turn_abort = 1'b0;
    vecs++; if (cc0 !== 3'd1) begin errs++; $display("FAIL start_abort: got cc %0d exp 1", cc0); end
  endtask

  task automatic test_async_reset();
    hand_value = 5'd12;
    startTurn();
    repeat (4) step();
    dealCard();
    repeat (4) step();
    vecs++; if (cmd0 !== COMMAND_HIT || cc0 !== 3'd1) begin errs++; $display("FAIL pre_reset: got cmd %0d cc %0d exp 1 1", cmd0, cc0); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (cmd0 !== COMMAND_NONE || cv0 !== 1'b0 || cc0 !== 3'd0 || done0 !== 1'b0 || bust0 !== 1'b0) begin errs++; $display("FAIL async_reset: got cmd %0d v %b cc %0d done %b bust %b exp all 0", cmd0, cv0, cc0, done0, bust0); end
    #2 rst_n = 1'b1;
    step(); step();
    vecs++; if (cv0 !== 1'b0 || cmd0 !== COMMAND_NONE) begin errs++; $display("FAIL post_reset_idle: got v %b cmd %0d exp 0 0", cv0, cmd0); end
  endtask

  initial begin
    test_reset();
    test_hit_then_stand();
    test_bust();
    test_soft17();
    test_max_cards();
    test_small_cap_zero_delay();
    test_abort_and_ignore();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
